// File: rtl/dcache_axi_bridge_pkg.sv
// Shared constants and state encoding for the dcache-to-AXI miss/uncached bridge.
package dcache_axi_bridge_pkg;

    localparam int DCACHE_LINE_WORDS = 16;
    localparam int DCACHE_ADDR_W     = 32;
    localparam int DCACHE_LINE_W     = DCACHE_LINE_WORDS * 32;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;

    typedef enum logic [5:0] {
        S_IDLE    = 6'b000001,
        S_RD_ADDR = 6'b000010,
        S_RD_DATA = 6'b000100,
        S_WR_ADDR = 6'b001000,
        S_WR_DATA = 6'b010000,
        S_WR_RESP = 6'b100000
    } bridge_state_t;

endpackage

// File: rtl/dcache_line_buf.sv
// Cache-line assembly buffer: one 32-bit lane written per beat, whole line always visible.
module dcache_line_buf #(
    parameter int LINE_WORDS = 16,
    parameter int IDX_W      = $clog2(LINE_WORDS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_we,
    input  logic [IDX_W-1:0]         i_idx,
    input  logic [31:0]              i_wdata,
    output logic [LINE_WORDS*32-1:0] o_line
);

    logic [31:0] r_words [LINE_WORDS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LINE_WORDS; i++) r_words[i] <= '0;
        end else if (i_we) begin
            r_words[i_idx] <= i_wdata;
        end
    end

    always_comb begin
        for (int i = 0; i < LINE_WORDS; i++) o_line[i*32 +: 32] = r_words[i];
    end

endmodule

// File: rtl/dcache_axi_bridge.sv
// Executes dcache line fills, write-backs and uncached word accesses as single
// outstanding AXI transactions, returning completion pulses and the fetched line.
//
// state   | meaning
// IDLE    | waiting for a request pulse; requests are latched here only
// RD_ADDR | AR valid, waiting for arready
// RD_DATA | accepting R beats until rlast
// WR_ADDR | AW valid, waiting for awready
// WR_DATA | issuing W beats
// WR_RESP | waiting for the B response
module dcache_axi_bridge
    import dcache_axi_bridge_pkg::*;
#(
    parameter int LINE_WORDS = DCACHE_LINE_WORDS,
    parameter int ADDR_W     = DCACHE_ADDR_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ca_rreq_i,
    input  logic                     ca_wreq_i,
    input  logic                     uc_rreq_i,
    input  logic                     uc_wreq_i,
    input  logic [ADDR_W-1:0]        addr_i,
    input  logic [LINE_WORDS*32-1:0] wline_i,
    input  logic [31:0]              uc_wdata_i,
    input  logic [3:0]               uc_wstrb_i,
    output logic [LINE_WORDS*32-1:0] cacheline_rdata_o,
    output logic                     rend_o,
    output logic                     write_ok_o,
    output logic                     wend_o,
    output logic                     busy_o,
    output logic [ADDR_W-1:0]        araddr_o,
    output logic [7:0]               arlen_o,
    output logic [2:0]               arsize_o,
    output logic [1:0]               arburst_o,
    output logic                     arvalid_o,
    input  logic                     arready_i,
    input  logic [31:0]              rdata_i,
    input  logic [1:0]               rresp_i,
    input  logic                     rlast_i,
    input  logic                     rvalid_i,
    output logic                     rready_o,
    output logic [ADDR_W-1:0]        awaddr_o,
    output logic [7:0]               awlen_o,
    output logic [2:0]               awsize_o,
    output logic [1:0]               awburst_o,
    output logic                     awvalid_o,
    input  logic                     awready_i,
    output logic [31:0]              wdata_o,
    output logic [3:0]               wstrb_o,
    output logic                     wlast_o,
    output logic                     wvalid_o,
    input  logic                     wready_i,
    input  logic [1:0]               bresp_i,
    input  logic                     bvalid_i,
    output logic                     bready_o
);

    localparam int         IDX_W  = $clog2(LINE_WORDS);
    localparam logic [7:0] CA_LEN = 8'(LINE_WORDS - 1);

    bridge_state_t           r_state, w_state_nxt;
    logic                    r_is_ca;
    logic [ADDR_W-1:0]       r_addr;
    logic [LINE_WORDS*32-1:0] r_wline;
    logic [31:0]             r_wdata;
    logic [3:0]              r_wstrb;
    logic [IDX_W-1:0]        r_cnt;
    logic                    r_rend, r_write_ok, r_wend;

    logic                    w_any_req, w_req_ca, w_req_wr;
    logic                    w_r_hs, w_w_hs, w_b_hs, w_w_last;
    logic [7:0]              w_len;
    logic [31:0]             w_wline_word;
    logic [IDX_W-1:0]        w_buf_idx;
    logic                    w_unused;

    // Response codes carry no error path in this bridge.
    assign w_unused = ^{rresp_i, bresp_i};

    assign w_any_req    = uc_rreq_i | uc_wreq_i | ca_rreq_i | ca_wreq_i;
    assign w_req_ca     = !uc_rreq_i && !uc_wreq_i;
    assign w_req_wr     = !uc_rreq_i && (uc_wreq_i || !ca_rreq_i);
    assign w_r_hs       = (r_state == S_RD_DATA) && rvalid_i;
    assign w_w_hs       = (r_state == S_WR_DATA) && wready_i;
    assign w_b_hs       = (r_state == S_WR_RESP) && bvalid_i;
    assign w_w_last     = r_is_ca ? (r_cnt == IDX_W'(LINE_WORDS - 1)) : 1'b1;
    assign w_len        = r_is_ca ? CA_LEN : 8'd0;
    assign w_wline_word = r_wline[{r_cnt, 5'b0} +: 32];
    assign w_buf_idx    = r_is_ca ? r_cnt : r_addr[IDX_W+1:2];

    assign rend_o     = r_rend;
    assign write_ok_o = r_write_ok;
    assign wend_o     = r_wend;
    assign busy_o     = (r_state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        arvalid_o   = 1'b0;
        araddr_o    = '0;
        arlen_o     = '0;
        arsize_o    = '0;
        arburst_o   = '0;
        rready_o    = 1'b0;
        awvalid_o   = 1'b0;
        awaddr_o    = '0;
        awlen_o     = '0;
        awsize_o    = '0;
        awburst_o   = '0;
        wvalid_o    = 1'b0;
        wdata_o     = '0;
        wstrb_o     = '0;
        wlast_o     = 1'b0;
        bready_o    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any_req) w_state_nxt = w_req_wr ? S_WR_ADDR : S_RD_ADDR;
            end
            S_RD_ADDR: begin
                arvalid_o = 1'b1;
                araddr_o  = r_addr;
                arlen_o   = w_len;
                arsize_o  = AXI_SIZE_WORD;
                arburst_o = AXI_BURST_INCR;
                if (arready_i) w_state_nxt = S_RD_DATA;
            end
            S_RD_DATA: begin
                rready_o = 1'b1;
                if (rvalid_i && rlast_i) w_state_nxt = S_IDLE;
            end
            S_WR_ADDR: begin
                awvalid_o = 1'b1;
                awaddr_o  = r_addr;
                awlen_o   = w_len;
                awsize_o  = AXI_SIZE_WORD;
                awburst_o = AXI_BURST_INCR;
                if (awready_i) w_state_nxt = S_WR_DATA;
            end
            S_WR_DATA: begin
                wvalid_o = 1'b1;
                wdata_o  = r_is_ca ? w_wline_word : r_wdata;
                wstrb_o  = r_is_ca ? 4'hF : r_wstrb;
                wlast_o  = w_w_last;
                if (wready_i && w_w_last) w_state_nxt = S_WR_RESP;
            end
            S_WR_RESP: begin
                bready_o = 1'b1;
                if (bvalid_i) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_is_ca    <= 1'b0;
            r_addr     <= '0;
            r_wline    <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_cnt      <= '0;
            r_rend     <= 1'b0;
            r_write_ok <= 1'b0;
            r_wend     <= 1'b0;
        end else begin
            r_rend     <= w_r_hs && rlast_i;
            r_write_ok <= w_b_hs && r_is_ca;
            r_wend     <= w_b_hs && !r_is_ca;
            if ((r_state == S_IDLE) && w_any_req) begin
                r_is_ca <= w_req_ca;
                r_addr  <= addr_i;
                r_wline <= wline_i;
                r_wdata <= uc_wdata_i;
                r_wstrb <= uc_wstrb_i;
                r_cnt   <= '0;
            end else if (w_r_hs || w_w_hs) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    dcache_line_buf #(
        .LINE_WORDS (LINE_WORDS),
        .IDX_W      (IDX_W)
    ) u_line_buf (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_r_hs),
        .i_idx   (w_buf_idx),
        .i_wdata (rdata_i),
        .o_line  (cacheline_rdata_o)
    );

endmodule

// File: tb/tb_dcache_axi_bridge.sv
// Self-checking bench for dcache_axi_bridge: vector table plus hand sequences,
// completions checked against a scoreboard queue filled when requests are driven.
module tb_dcache_axi_bridge;

    localparam int LW     = 16;
    localparam int LINE_W = LW * 32;
    localparam int K_CA_RD = 0, K_CA_WR = 1, K_UC_RD = 2, K_UC_WR = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ca_rreq_i = 0, ca_wreq_i = 0, uc_rreq_i = 0, uc_wreq_i = 0;
    logic [31:0] addr_i = '0;
    logic [LINE_W-1:0] wline_i = '0;
    logic [31:0] uc_wdata_i = '0;
    logic [3:0]  uc_wstrb_i = '0;
    logic [LINE_W-1:0] cacheline_rdata_o;
    logic rend_o, write_ok_o, wend_o, busy_o;
    logic [31:0] araddr_o, awaddr_o;
    logic [7:0]  arlen_o, awlen_o;
    logic [2:0]  arsize_o, awsize_o;
    logic [1:0]  arburst_o, awburst_o;
    logic arvalid_o, awvalid_o, rready_o, wvalid_o, wlast_o, bready_o;
    logic arready_i = 0, rlast_i = 0, rvalid_i = 0, awready_i = 0, wready_i = 0, bvalid_i = 0;
    logic [31:0] rdata_i = '0;
    logic [1:0]  rresp_i = '0, bresp_i = '0;
    logic [31:0] wdata_o;
    logic [3:0]  wstrb_o;

    dcache_axi_bridge #(.LINE_WORDS(LW), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .ca_rreq_i(ca_rreq_i), .ca_wreq_i(ca_wreq_i), .uc_rreq_i(uc_rreq_i), .uc_wreq_i(uc_wreq_i),
        .addr_i(addr_i), .wline_i(wline_i), .uc_wdata_i(uc_wdata_i), .uc_wstrb_i(uc_wstrb_i),
        .cacheline_rdata_o(cacheline_rdata_o), .rend_o(rend_o), .write_ok_o(write_ok_o),
        .wend_o(wend_o), .busy_o(busy_o),
        .araddr_o(araddr_o), .arlen_o(arlen_o), .arsize_o(arsize_o), .arburst_o(arburst_o),
        .arvalid_o(arvalid_o), .arready_i(arready_i),
        .rdata_i(rdata_i), .rresp_i(rresp_i), .rlast_i(rlast_i), .rvalid_i(rvalid_i), .rready_o(rready_o),
        .awaddr_o(awaddr_o), .awlen_o(awlen_o), .awsize_o(awsize_o), .awburst_o(awburst_o),
        .awvalid_o(awvalid_o), .awready_i(awready_i),
        .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wlast_o(wlast_o), .wvalid_o(wvalid_o), .wready_i(wready_i),
        .bresp_i(bresp_i), .bvalid_i(bvalid_i), .bready_o(bready_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int req_cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int           kind;
        logic [LINE_W-1:0] line;
    } sb_t;
    sb_t sb_q[$];
    logic [LINE_W-1:0] model_line = '0;

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [3:0]  ws;
        logic [31:0] base;
        int          d;
        bit          tog;
        int          exp_len;
        logic [3:0]  exp_strb;
    } vec_t;
    vec_t vecs[7];

    task automatic chk(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] exp_pulse(input int kind);
        if (kind == K_CA_RD || kind == K_UC_RD) return 3'b100;
        if (kind == K_CA_WR) return 3'b010;
        return 3'b001;
    endfunction

    function automatic logic [3:0] kind_bits(input int kind);
        case (kind)
            K_UC_RD: return 4'b1000;
            K_UC_WR: return 4'b0100;
            K_CA_RD: return 4'b0010;
            default: return 4'b0001;
        endcase
    endfunction

    // Completion monitor: every pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        sb_t e;
        if (!rst && (rend_o || write_ok_o || wend_o)) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_completion: rend=%0b write_ok=%0b wend=%0b with none pending",
                         rend_o, write_ok_o, wend_o);
            end else begin
                e = sb_q.pop_front();
                chk("done_pulse", {rend_o, write_ok_o, wend_o}, exp_pulse(e.kind));
                if (e.kind == K_CA_RD || e.kind == K_UC_RD) chk("line_data", cacheline_rdata_o, e.line);
            end
        end
    end

    // Drive the request pulse at the current negedge; returns one negedge later.
    task automatic issue(input logic [3:0] reqs, input logic [31:0] addr, input logic [LINE_W-1:0] wl,
                         input logic [31:0] wd, input logic [3:0] ws);
        {uc_rreq_i, uc_wreq_i, ca_rreq_i, ca_wreq_i} = reqs;
        addr_i = addr; wline_i = wl; uc_wdata_i = wd; uc_wstrb_i = ws;
        req_cyc = cyc;
        @(negedge clk);
        {uc_rreq_i, uc_wreq_i, ca_rreq_i, ca_wreq_i} = 4'b0000;
    endtask

    task automatic slave_read(input logic [31:0] exp_addr, input int len, input int d,
                              input logic [31:0] base, input int stop_after, input int exp_lat);
        int k;
        for (int i = 0; i < d; i++) begin
            chk("arvalid_hold", arvalid_o, 1'b1);
            arready_i = 0;
            @(negedge clk);
        end
        chk("arvalid", arvalid_o, 1'b1);
        chk("araddr", araddr_o, exp_addr);
        chk("arlen", arlen_o, len);
        chk("arsize", arsize_o, 3'b010);
        chk("arburst", arburst_o, 2'b01);
        arready_i = 1;
        @(negedge clk);
        arready_i = 0;
        chk("arvalid_drop", arvalid_o, 1'b0);
        for (int n = 0; n <= len && n < stop_after; n++) begin
            chk("rready", rready_o, 1'b1);
            rvalid_i = 1; rdata_i = base + n; rlast_i = (n == len);
            @(negedge clk);
        end
        rvalid_i = 0; rlast_i = 0;
        if (stop_after <= len) return;
        k = 0;
        while (!rend_o && k < 40) begin @(negedge clk); k++; end
        chk("rend_seen", rend_o, 1'b1);
        chk("rd_latency", cyc - req_cyc, exp_lat);
        chk("busy_at_rend", busy_o, 1'b0);
    endtask

    task automatic slave_write(input logic [31:0] exp_addr, input int len, input int d, input bit tog,
                               input logic [LINE_W-1:0] wl, input logic [31:0] wd,
                               input logic [3:0] exp_strb, input bit is_ca);
        int beat, guard;
        logic [31:0] expw;
        for (int i = 0; i < d; i++) begin
            chk("awvalid_hold", awvalid_o, 1'b1);
            chk("w_before_aw", wvalid_o, 1'b0);
            awready_i = 0;
            @(negedge clk);
        end
        chk("awvalid", awvalid_o, 1'b1);
        chk("awaddr", awaddr_o, exp_addr);
        chk("awlen", awlen_o, len);
        chk("awsize", awsize_o, 3'b010);
        chk("awburst", awburst_o, 2'b01);
        awready_i = 1;
        @(negedge clk);
        awready_i = 0;
        beat = 0; guard = 0;
        while (beat <= len && guard < 100) begin
            wready_i = tog ? (guard % 2 == 1) : 1'b1;
            if (wvalid_o && wready_i) begin
                expw = is_ca ? wl[beat*32 +: 32] : wd;
                chk("wdata", wdata_o, expw);
                chk("wstrb", wstrb_o, exp_strb);
                chk("wlast", wlast_o, beat == len);
                beat++;
            end
            @(negedge clk);
            guard++;
        end
        wready_i = 0;
        chk("w_beats", beat, len + 1);
        chk("wvalid_after_last", wvalid_o, 1'b0);
        chk("bready", bready_o, 1'b1);
        @(negedge clk);
        bvalid_i = 1;
        @(negedge clk);
        bvalid_i = 0;
        chk("wr_done", is_ca ? write_ok_o : wend_o, 1'b1);
        chk("busy_at_wdone", busy_o, 1'b0);
    endtask

    task automatic run_vec(input vec_t v);
        logic [LINE_W-1:0] wl;
        sb_t e;
        int idx;
        for (int n = 0; n < LW; n++) wl[n*32 +: 32] = v.base + n;
        idx = int'(v.addr[5:2]);
        if (v.kind == K_CA_RD) model_line = wl;
        else if (v.kind == K_UC_RD) model_line[idx*32 +: 32] = v.base;
        e.kind = v.kind;
        e.line = model_line;
        sb_q.push_back(e);
        issue(kind_bits(v.kind), v.addr, wl, v.base, v.ws);
        if (v.kind == K_CA_RD || v.kind == K_UC_RD)
            slave_read(v.addr, v.exp_len, v.d, v.base, 99, 3 + v.d + v.exp_len);
        else
            slave_write(v.addr, v.exp_len, v.d, v.tog, wl, v.base, v.exp_strb, v.kind == K_CA_WR);
        @(negedge clk);
    endtask

    task automatic expect_quiet(input int ncyc, input string name);
        int seen;
        seen = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (arvalid_o || awvalid_o || busy_o) seen++;
        end
        chk(name, seen, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        sb_t e;
        logic [LINE_W-1:0] wl;
        vec_t v;

        vecs[0] = '{K_CA_RD, 32'h1FC0_0040, 4'h0, 32'h0000_0100, 0, 1'b0, 15, 4'h0};
        vecs[1] = '{K_CA_WR, 32'h1FC0_0080, 4'h0, 32'h0000_00A0, 3, 1'b1, 15, 4'hF};
        vecs[2] = '{K_UC_RD, 32'hBFAF_8014, 4'h0, 32'hDEAD_BEEF, 0, 1'b0, 0,  4'h0};
        vecs[3] = '{K_UC_WR, 32'hBFAF_0008, 4'h3, 32'h1234_5678, 0, 1'b0, 0,  4'h3};
        vecs[4] = '{K_CA_RD, 32'h0000_1000, 4'h0, 32'h0000_0200, 2, 1'b0, 15, 4'h0};
        vecs[5] = '{K_UC_RD, 32'h0000_103C, 4'h0, 32'hCAFE_0001, 1, 1'b0, 0,  4'h0};
        vecs[6] = '{K_UC_WR, 32'h8000_0004, 4'hC, 32'h0BAD_F00D, 2, 1'b1, 0,  4'hC};

        repeat (2) @(negedge clk);
        chk("reset_ctrl", {arvalid_o, awvalid_o, wvalid_o, rready_o, bready_o, rend_o, write_ok_o,
                           wend_o, busy_o, wlast_o}, 10'b0);
        chk("reset_payload", {araddr_o, arlen_o, awaddr_o, awlen_o, wdata_o, wstrb_o}, '0);
        chk("reset_line", cacheline_rdata_o, '0);
        rst = 0;
        @(negedge clk);

        for (int t = 0; t < 7; t++) run_vec(vecs[t]);

        // Write-back followed by a fill requested in the write_ok cycle.
        for (int n = 0; n < LW; n++) wl[n*32 +: 32] = 32'h300 + n;
        e.kind = K_CA_WR; e.line = '0;
        sb_q.push_back(e);
        issue(4'b0001, 32'h0000_2000, wl, 32'h0, 4'h0);
        slave_write(32'h0000_2000, 15, 0, 1'b1, wl, 32'h0, 4'hF, 1'b1);
        for (int n = 0; n < LW; n++) model_line[n*32 +: 32] = 32'h400 + n;
        e.kind = K_CA_RD; e.line = model_line;
        sb_q.push_back(e);
        issue(4'b0010, 32'h0000_3000, '0, 32'h0, 4'h0);
        slave_read(32'h0000_3000, 15, 0, 32'h400, 99, 18);
        @(negedge clk);

        // Simultaneous uc read + ca write-back, then a ca fill pulsed while busy.
        model_line[2*32 +: 32] = 32'h5555_AAAA;
        e.kind = K_UC_RD; e.line = model_line;
        sb_q.push_back(e);
        issue(4'b1001, 32'h1000_0008, {LW{32'hFFFF_0000}}, 32'h0, 4'h0);
        ca_rreq_i = 1; addr_i = 32'h2000_0000;
        @(negedge clk);
        ca_rreq_i = 0;
        slave_read(32'h1000_0008, 0, 2, 32'h5555_AAAA, 99, 6);
        expect_quiet(5, "no_extra_txn");

        // Reset in the middle of a line fill, after beat 7.
        issue(4'b0010, 32'h0000_4000, '0, 32'h0, 4'h0);
        slave_read(32'h0000_4000, 15, 0, 32'h500, 8, 0);
        rst = 1;
        #1;
        chk("rst_mid_ctrl", {arvalid_o, awvalid_o, wvalid_o, rready_o, bready_o, rend_o, write_ok_o,
                             wend_o, busy_o}, 9'b0);
        chk("rst_mid_line", cacheline_rdata_o, '0);
        model_line = '0;
        @(negedge clk);
        rst = 0;
        expect_quiet(4, "idle_after_reset");
        v = '{K_UC_RD, 32'h0000_4024, 4'h0, 32'h7777_0009, 0, 1'b0, 0, 4'h0};
        run_vec(v);

        repeat (3) @(negedge clk);
        chk("sb_drained", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dcache_axi_bridge.md
# dcache_axi_bridge

Memory-side responder for the data cache's miss/uncached request interface. It accepts the single-cycle request pulses issued by the cache's second stage: cached line fill, dirty line write-back, uncached word read and uncached word write. It executes each one as an AXI master transaction and returns completion pulses plus the fetched line. It sits between the dcache and the top-level AXI crossbar, one outstanding transaction at a time.

## Interface
- LINE_WORDS, 16, words per cache line (burst length); line width = LINE_WORDS*32
- ADDR_W, 32, address width
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- ca_rreq_i / ca_wreq_i / uc_rreq_i / uc_wreq_i  in  1 each  request pulses, one cycle
- addr_i  in  ADDR_W  request address (line-aligned for ca_*, word address for uc_*)
- wline_i  in  LINE_WORDS*32  dirty line for write-back, valid with ca_wreq_i
- uc_wdata_i  in  32  uncached write data; uc_wstrb_i  in  4  byte strobes
- cacheline_rdata_o  out  LINE_WORDS*32  returned line; word k at bits [32k+31:32k]
- rend_o  out  1  read (ca or uc) complete pulse
- write_ok_o  out  1  write-back complete pulse; wend_o  out  1  uncached write complete pulse
- busy_o  out  1  transaction in flight
- AR: araddr_o[ADDR_W], arlen_o[8], arsize_o[3], arburst_o[2], arvalid_o out; arready_i in
- R: rdata_i[32], rresp_i[2], rlast_i, rvalid_i in; rready_o out
- AW: awaddr_o, awlen_o, awsize_o, awburst_o, awvalid_o out; awready_i in
- W: wdata_o[32], wstrb_o[4], wlast_o, wvalid_o out; wready_i in
- B: bresp_i[2], bvalid_i in; bready_o out

## Operation
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_RESP.
- IDLE: sample requests; priority uc_rreq > uc_wreq > ca_rreq > ca_wreq; latch kind, addr, wline/wdata/wstrb. Requests outside IDLE are ignored (no latching).
- Read: arlen = LINE_WORDS-1 (ca) or 0 (uc); arsize 3'b010; arburst INCR; araddr = addr_i (ca line-aligned, low 6 bits zero).
- RD_DATA: rready_o=1; ca beat n written to word n (4-bit counter, wraps after beat 15); uc beat written to word addr[5:2], other words unchanged.
- Write: awlen LINE_WORDS-1 (ca, wstrb 4'hF, beat n = wline word n) or 0 (uc, wstrb = uc_wstrb_i); wlast_o on final beat.
- W beats only after AW handshake; WR_RESP: bready_o=1 until bvalid_i.
- rresp/bresp ignored (no error path).

## Timing
- Reset: all outputs 0, cacheline_rdata_o 0, FSM IDLE; reset mid-transaction abandons it, no completion pulse.
- Request sampled at cycle T; arvalid_o/awvalid_o asserted from T+1, held until ready (AXI valid-stability rule).
- rend_o: one cycle, cycle after the rlast_i handshake; cacheline_rdata_o stable from that cycle until next read beat.
- write_ok_o (ca) / wend_o (uc): one cycle, cycle after B handshake; FSM in IDLE the same cycle, so a ca_rreq_i arriving the next cycle is accepted.
- Zero-wait slave, ca read: AR hs T+1, beats T+2..T+17, rend_o T+18.
- busy_o = (state != IDLE); valid low in IDLE.

## Structure
- Shared defines_cache.v additions: AXI_BURST_INCR 2'b01, AXI_SIZE_WORD 3'b010, DCACHE_LINE_W, bridge state encodings (one-hot, 6 bits).
- One sub-module: dcache_line_buf (LINE_WORDS x 32 register, word-lane write enable by index, full-line read, async active-high reset).
- Control FSM, beat counter and AXI channel registers stay in the top module.

## Test plan
- ca_rreq, addr 0x1FC0_0040, slave data 0x100+n per beat, zero wait -> arlen 15, araddr 0x1FC0_0040, rend_o at T+18, word 5 = 0x105.
- ca_wreq, wline word n = 0xA0+n, awready delayed 3 cycles, wready toggling -> 16 beats 0xA0..0xAF in order, wlast on beat 15, single write_ok_o after B, then ca_rreq next cycle accepted.
- uc_rreq addr 0xBFAF_8014, rdata 0xDEAD_BEEF -> arlen 0, word 5 = 0xDEADBEEF, other words unchanged, rend_o once.
- uc_wreq addr 0xBFAF_0008, wdata 0x1234_5678, wstrb 4'b0011 -> awlen 0, wstrb_o 4'b0011, wlast_o=1, wend_o once.
- uc_rreq and ca_wreq same cycle -> uc read only; ca_rreq pulsed while busy -> ignored, no AR issued.
- rst asserted mid ca read (after beat 7) -> all valids 0 immediately, no rend_o, next request starts clean from IDLE.
